// File: rtl/xintf_pkg.sv
// Shared types and constants for the XINTF read responder.
package xintf_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 20;
  localparam int NUM_WORDS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DRIVE  = 2'd2,
    TURN   = 2'd3
  } xintf_state_t;

  // Word offsets from the window base
  localparam logic [3:0] OFS_STATUS = 4'd0;
  localparam logic [3:0] OFS_W1     = 4'd1;
  localparam logic [3:0] OFS_W2     = 4'd2;
  localparam logic [3:0] OFS_W3     = 4'd3;
  localparam logic [3:0] OFS_W4     = 4'd4;
  localparam logic [3:0] OFS_W5     = 4'd5;
  localparam logic [3:0] OFS_W6     = 4'd6;
  localparam logic [3:0] OFS_W7     = 4'd7;
  localparam logic [3:0] OFS_W8     = 4'd8;

endpackage

// File: rtl/xintf_read_resp_if.sv
// DSP-side XINTF control/address signals; the DSP is master, the FPGA responder is slave.
interface xintf_read_resp_if;
  import xintf_pkg::*;

  logic              cs_n;
  logic              rd_n;
  logic [ADDR_W-1:0] xadd;

  modport master (output cs_n, output rd_n, output xadd);
  modport slave  (input  cs_n, input  rd_n, input  xadd);

endinterface

// File: rtl/xintf_sync.sv
// Multi-stage synchronizer for an active-low asynchronous strobe; resets to the inactive level (1).
module xintf_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic global_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) ff <= '1;
    else             ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/xintf_read_resp.sv
// FPGA-to-DSP read responder: decodes a 9-word XINTF window and drives xdata during DSP reads.
// Optional coherent multi-word snapshot of words 2..8 when XINTF_SNAPSHOT_EN is defined.
module xintf_read_resp
  import xintf_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 20'h0FC10,
  parameter int                SYNC_STAGES  = 2,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = 16'h0000
) (
  input  logic               clk,
  input  logic               global_rst,
  xintf_read_resp_if.slave   bus,
  inout  wire  [DATA_W-1:0]  xdata,
  input  logic [DATA_W-1:0]  fpga2dsp1,
  input  logic [DATA_W-1:0]  fpga2dsp2,
  input  logic [DATA_W-1:0]  fpga2dsp3,
  input  logic [DATA_W-1:0]  fpga2dsp4,
  input  logic [DATA_W-1:0]  fpga2dsp5,
  input  logic [DATA_W-1:0]  fpga2dsp6,
  input  logic [DATA_W-1:0]  fpga2dsp7,
  input  logic [DATA_W-1:0]  fpga2dsp8,
  output logic               rd_strobe,
  output logic               addr_err,
  output logic [DATA_W-1:0]  rd_count
);

  // state  | meaning
  // IDLE   | bus released, waiting for a fresh read-active edge
  // DECODE | latch data word selected by the registered address
  // DRIVE  | xdata driven with frozen data while the read stays active
  // TURN   | one clk of bus turnaround, completion pulse issued

  xintf_state_t state, next_state;

  logic              cs_s, rd_s, rd_act;
  logic              armed;
  logic [ADDR_W-1:0] xadd_q;
  logic [ADDR_W-1:0] ofs;
  logic              in_win;
  logic [DATA_W-1:0] dout_reg, dec_data;
  logic              err_q, dec_err;
  logic              oe;
  logic              complete;
  logic [DATA_W-1:0] src [1:NUM_WORDS];

  xintf_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .global_rst(global_rst), .d(bus.cs_n), .q(cs_s)
  );

  xintf_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .global_rst(global_rst), .d(bus.rd_n), .q(rd_s)
  );

  assign rd_act = !cs_s && !rd_s;

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) xadd_q <= '0;
    else             xadd_q <= bus.xadd;
  end

  // Addresses below the base wrap to large offsets and fall outside the window
  assign ofs    = xadd_q - BASE_ADDR;
  assign in_win = (ofs <= ADDR_W'(NUM_WORDS));

`ifdef XINTF_SNAPSHOT_EN
  logic [DATA_W-1:0] shadow [2:NUM_WORDS];

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      for (int i = 2; i <= NUM_WORDS; i++) shadow[i] <= '0;
    end else if (state == DECODE && in_win && ofs[3:0] == OFS_W1) begin
      shadow[2] <= fpga2dsp2;
      shadow[3] <= fpga2dsp3;
      shadow[4] <= fpga2dsp4;
      shadow[5] <= fpga2dsp5;
      shadow[6] <= fpga2dsp6;
      shadow[7] <= fpga2dsp7;
      shadow[8] <= fpga2dsp8;
    end
  end

  assign src[1] = fpga2dsp1;
  assign src[2] = shadow[2];
  assign src[3] = shadow[3];
  assign src[4] = shadow[4];
  assign src[5] = shadow[5];
  assign src[6] = shadow[6];
  assign src[7] = shadow[7];
  assign src[8] = shadow[8];
`else
  assign src[1] = fpga2dsp1;
  assign src[2] = fpga2dsp2;
  assign src[3] = fpga2dsp3;
  assign src[4] = fpga2dsp4;
  assign src[5] = fpga2dsp5;
  assign src[6] = fpga2dsp6;
  assign src[7] = fpga2dsp7;
  assign src[8] = fpga2dsp8;
`endif

  always_comb begin
    dec_data = DEFAULT_DATA;
    dec_err  = 1'b1;
    if (in_win) begin
      dec_err = 1'b0;
      case (ofs[3:0])
        OFS_STATUS: dec_data = rd_count;
        OFS_W1:     dec_data = src[1];
        OFS_W2:     dec_data = src[2];
        OFS_W3:     dec_data = src[3];
        OFS_W4:     dec_data = src[4];
        OFS_W5:     dec_data = src[5];
        OFS_W6:     dec_data = src[6];
        OFS_W7:     dec_data = src[7];
        OFS_W8:     dec_data = src[8];
        default:    dec_err  = 1'b1;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rd_act && armed) next_state = DECODE;
      DECODE:  next_state = DRIVE;
      DRIVE:   if (!rd_act) next_state = TURN;
      TURN:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign complete = (state == DRIVE) && !rd_act;

  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      state     <= IDLE;
      armed     <= 1'b1;
      dout_reg  <= '0;
      err_q     <= 1'b0;
      oe        <= 1'b0;
      rd_strobe <= 1'b0;
      addr_err  <= 1'b0;
      rd_count  <= '0;
    end else begin
      state     <= next_state;
      oe        <= (next_state == DRIVE);
      rd_strobe <= complete && !err_q;
      addr_err  <= complete && err_q;
      // One DSP access arms exactly one decode; re-arm only once rd_act has dropped
      if (next_state == DECODE) armed <= 1'b0;
      else if (!rd_act)         armed <= 1'b1;
      if (state == DECODE) begin
        dout_reg <= dec_data;
        err_q    <= dec_err;
      end
      if (complete && !err_q) rd_count <= rd_count + 16'd1;
    end
  end

  assign xdata = oe ? dout_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_xintf_read_resp.sv
// Directed self-checking bench for xintf_read_resp (default build or XINTF_SNAPSHOT_EN).
module tb_xintf_read_resp;

  logic        clk;
  logic        global_rst;
  wire  [15:0] xdata;
  logic [15:0] fpga2dsp1, fpga2dsp2, fpga2dsp3, fpga2dsp4;
  logic [15:0] fpga2dsp5, fpga2dsp6, fpga2dsp7, fpga2dsp8;
  logic        rd_strobe;
  logic        addr_err;
  logic [15:0] rd_count;

  int n_chk  = 0;
  int n_pass = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;

`ifdef XINTF_SNAPSHOT_EN
  localparam logic [15:0] EXP_W5 = 16'h1234;
`else
  localparam logic [15:0] EXP_W5 = 16'h5678;
`endif

  xintf_read_resp_if bus ();

  xintf_read_resp dut (
    .clk        (clk),
    .global_rst (global_rst),
    .bus        (bus),
    .xdata      (xdata),
    .fpga2dsp1  (fpga2dsp1),
    .fpga2dsp2  (fpga2dsp2),
    .fpga2dsp3  (fpga2dsp3),
    .fpga2dsp4  (fpga2dsp4),
    .fpga2dsp5  (fpga2dsp5),
    .fpga2dsp6  (fpga2dsp6),
    .fpga2dsp7  (fpga2dsp7),
    .fpga2dsp8  (fpga2dsp8),
    .rd_strobe  (rd_strobe),
    .addr_err   (addr_err),
    .rd_count   (rd_count)
  );

  // Released bus reads back as 0
  pulldown (xdata);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_strobe) strobe_cnt++;
    if (addr_err)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Full read: rd_n/cs_n low for low_clks clocks, data sampled 4 clks after the fall
  task automatic rd_cycle(input logic [19:0] a, input int low_clks, output logic [15:0] got);
    @(negedge clk);
    bus.xadd = a; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (4) @(negedge clk);
    got = xdata;
    repeat (low_clks - 4) @(negedge clk);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  logic [15:0] got;

  initial begin
    global_rst = 1'b0;
    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.xadd = '0;
    fpga2dsp1 = 16'h0101; fpga2dsp2 = 16'h2222; fpga2dsp3 = 16'hA5A5; fpga2dsp4 = 16'h1111;
    fpga2dsp5 = 16'h1234; fpga2dsp6 = 16'h6666; fpga2dsp7 = 16'h7777; fpga2dsp8 = 16'h8888;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_xdata", xdata, 16'h0000);
    chk("rst_strobe", {15'd0, rd_strobe}, 16'd0);
    chk("rst_err", {15'd0, addr_err}, 16'd0);
    chk("rst_count", rd_count, 16'd0);
    global_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Mapped read of word 3 with cycle-accurate latency and frozen data
    @(negedge clk);
    bus.xadd = 20'h0FC13; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("map_pre_valid", xdata, 16'h0000);
    @(negedge clk);
    chk("map_valid_clk4", xdata, 16'hA5A5);
    bus.xadd = 20'h0FC14;
    repeat (4) @(negedge clk);
    chk("map_frozen", xdata, 16'hA5A5);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("map_hold_sync", xdata, 16'hA5A5);
    @(negedge clk);
    chk("map_strobe", {15'd0, rd_strobe}, 16'd1);
    chk("map_count", rd_count, 16'd1);
    chk("map_turn_z", xdata, 16'h0000);
    @(negedge clk);
    chk("map_strobe_end", {15'd0, rd_strobe}, 16'd0);
    repeat (2) @(negedge clk);
    chk("map_strobe_cnt", 16'(strobe_cnt), 16'd1);

    // Unmapped reads above and below the window, plus top mapped word
    rd_cycle(20'h0FC1F, 6, got);
    chk("unmap_hi_data", got, 16'h0000);
    chk("unmap_hi_err", 16'(err_cnt), 16'd1);
    chk("unmap_hi_count", rd_count, 16'd1);
    rd_cycle(20'h0FC0F, 6, got);
    chk("unmap_lo_err", 16'(err_cnt), 16'd2);
    rd_cycle(20'h0FC18, 6, got);
    chk("w8_data", got, 16'h8888);
    chk("w8_count", rd_count, 16'd2);
    rd_cycle(20'h0FC19, 6, got);
    chk("unmap_edge_err", 16'(err_cnt), 16'd3);
    chk("unmap_edge_count", rd_count, 16'd2);

    // Status read returns the pre-increment count
    rd_cycle(20'h0FC10, 6, got);
    chk("status_data", got, 16'd2);
    chk("status_count", rd_count, 16'd3);

    // Snapshot: word 1 read, then change word 5 live, then read word 5
    rd_cycle(20'h0FC11, 6, got);
    chk("snap_w1", got, 16'h0101);
    fpga2dsp5 = 16'h5678;
    rd_cycle(20'h0FC15, 6, got);
    chk("snap_w5", got, EXP_W5);
    chk("snap_count", rd_count, 16'd5);
    chk("snap_strobes", 16'(strobe_cnt), 16'd5);

    // cs_n abort in DRIVE with a second access arriving during TURN
    @(negedge clk);
    bus.xadd = 20'h0FC12; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_data", xdata, 16'h2222);
    @(negedge clk);
    bus.cs_n = 1'b1;
    @(negedge clk);
    bus.cs_n = 1'b0; bus.xadd = 20'h0FC13;
    @(negedge clk);
    chk("abort_drive", xdata, 16'h2222);
    @(negedge clk);
    chk("abort_strobe", {15'd0, rd_strobe}, 16'd1);
    chk("abort_turn_z", xdata, 16'h0000);
    @(negedge clk);
    chk("abort_idle_z", xdata, 16'h0000);
    @(negedge clk);
    chk("b2b_decode_z", xdata, 16'h0000);
    @(negedge clk);
    chk("b2b_data", xdata, 16'hA5A5);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("b2b_strobes", 16'(strobe_cnt), 16'd7);
    chk("b2b_count", rd_count, 16'd7);

    // Async reset in the middle of DRIVE
    @(negedge clk);
    bus.xadd = 20'h0FC13; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid_pre", xdata, 16'hA5A5);
    global_rst = 1'b0;
    #1;
    chk("rstmid_z", xdata, 16'h0000);
    chk("rstmid_count", rd_count, 16'd0);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1;
    @(negedge clk);
    global_rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_no_pulse", 16'(strobe_cnt), 16'd7);
    chk("rstmid_err", 16'(err_cnt), 16'd3);

    // Counter wrap at the status address
    @(negedge clk);
    force dut.rd_count = 16'hFFFF;
    @(negedge clk);
    release dut.rd_count;
    @(negedge clk);
    chk("wrap_preload", rd_count, 16'hFFFF);
    rd_cycle(20'h0FC10, 6, got);
    chk("wrap_data", got, 16'hFFFF);
    chk("wrap_count", rd_count, 16'h0000);
    chk("wrap_strobes", 16'(strobe_cnt), 16'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
